fft_unscrambler: RTL



---
 rtl/fft_pkg.sv | 24 ++
 rtl/fft_unscrambler_if.sv | 26 ++
 rtl/fft_dpram.sv | 29 ++
 rtl/fft_unscrambler.sv | 103 ++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT buffering definitions: default widths, buffer FSM states and
// the bit-reversal helper used to map FFT output order to bin index.
package fft_pkg;

  localparam int DEF_LGSIZE = 6;
  localparam int DEF_DW     = 16;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } state_t;

  // Reverses the low 'width' bits of value (width <= 12); upper bits return 0.
  function automatic logic [11:0] bitrev(input logic [11:0] value, input int unsigned width);
    logic [11:0] r;
    r = '0;
    for (int unsigned i = 0; i < 12; i++) begin
      if (i < width) r[i[3:0]] = value[4'(width - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_unscrambler_if.sv
// Sample-stream bundle for the unscrambler: FFT-side strobe/sync/data in,
// natural-order valid/ready stream plus status out.
interface fft_unscrambler_if #(
  parameter int DW = 16
);
  logic          i_ce;
  logic          i_sync;
  logic [DW-1:0] i_val;
  logic          o_busy;
  logic          o_overflow;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_val;
  logic          o_sync;
  logic          o_last;

  modport slave (
    input  i_ce, i_sync, i_val, i_ready,
    output o_busy, o_overflow, o_valid, o_val, o_sync, o_last
  );

  modport master (
    output i_ce, i_sync, i_val, i_ready,
    input  o_busy, o_overflow, o_valid, o_val, o_sync, o_last
  );
endinterface

// File: rtl/fft_dpram.sv
// Simple dual-port RAM, one write and one registered read port.
// The read register holds while i_re is low, so it can act as an output stage.
module fft_dpram #(
  parameter int DW = 16,
  parameter int AW = 6
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)   rdata_q <= '0;
    else if (i_re) rdata_q <= mem_q[i_raddr];
  end

  assign o_rdata = rdata_q;
endmodule

// File: rtl/fft_unscrambler.sv
// Buffers one bit-reversed FFT frame and replays it in natural bin order
// over a valid/ready stream; input arriving during replay is dropped and flagged.
module fft_unscrambler
  import fft_pkg::*;
#(
  parameter int LGSIZE = DEF_LGSIZE,
  parameter int DW     = DEF_DW
) (
  input logic                i_clk,
  input logic                i_reset,
  fft_unscrambler_if.slave   bus
);
  localparam logic [LGSIZE:0] LAST = {1'b0, {LGSIZE{1'b1}}};
  localparam logic [LGSIZE:0] FULL = {1'b1, {LGSIZE{1'b0}}};

  state_t            state_q;
  logic [LGSIZE:0]   wcount_q, rcount_q;
  logic              busy_q, ovf_q, valid_q, sync_q, last_q;
  logic              wr_en, rd_en;
  logic [LGSIZE-1:0] wr_addr;

  // The RAM read register doubles as the output register: a read is issued
  // whenever that stage is empty or being consumed, hiding the read latency.
  always_comb begin
    wr_en   = bus.i_ce && ((state_q == IDLE && bus.i_sync) || state_q == FILL);
    wr_addr = bus.i_sync ? '0 : LGSIZE'(bitrev(12'(wcount_q), LGSIZE));
    rd_en   = (state_q == DRAIN) && (rcount_q != FULL) && (!valid_q || bus.i_ready);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      wcount_q <= '0;
      rcount_q <= '0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      sync_q   <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_ce && bus.i_sync) begin
            wcount_q <= {{LGSIZE{1'b0}}, 1'b1};
            state_q  <= FILL;
          end
        end
        FILL: begin
          if (bus.i_ce) begin
            if (bus.i_sync) begin
              wcount_q <= {{LGSIZE{1'b0}}, 1'b1};
            end else if (wcount_q == LAST) begin
              wcount_q <= '0;
              rcount_q <= '0;
              busy_q   <= 1'b1;
              state_q  <= DRAIN;
            end else begin
              wcount_q <= wcount_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (bus.i_ce) ovf_q <= 1'b1;
          if (rd_en) begin
            rcount_q <= rcount_q + 1'b1;
            valid_q  <= 1'b1;
            sync_q   <= (rcount_q == '0);
            last_q   <= (rcount_q == LAST);
          end else if (bus.i_ready) begin
            valid_q <= 1'b0;
            sync_q  <= 1'b0;
            last_q  <= 1'b0;
          end
          if (valid_q && bus.i_ready && last_q) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  fft_dpram #(
    .DW(DW),
    .AW(LGSIZE)
  ) u_ram (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_we    (wr_en),
    .i_waddr (wr_addr),
    .i_wdata (bus.i_val),
    .i_re    (rd_en),
    .i_raddr (rcount_q[LGSIZE-1:0]),
    .o_rdata (bus.o_val)
  );

  assign bus.o_busy     = busy_q;
  assign bus.o_overflow = ovf_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_sync     = sync_q;
  assign bus.o_last     = last_q;
endmodule
